// File: rtl/stall_controller_if.sv
// rtl/stall_controller_if.sv - hazard inputs and stall/bubble controls between pipeline and stall_controller
interface stall_controller_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_mc_start;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  stall_mem;
  logic                  bubble_ex;
  logic                  bubble_mem;
  logic                  bubble_wb;
  logic [1:0]            fsm_state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_mc_start, mem_req, mem_ready,
    input  stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, fsm_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_mc_start, mem_req, mem_ready,
    output stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, fsm_state
  );
endinterface

// File: rtl/stall_controller.sv
// rtl/stall_controller.sv - per-stage stall/bubble control for the 5-stage pipeline
// Define STALL_PERF_EN to add saturating perf counters for each stall source.
module stall_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 3
`ifdef STALL_PERF_EN
  , parameter int PERF_W   = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  stall_controller_if.slave  bus
`ifdef STALL_PERF_EN
  , output logic [PERF_W-1:0] perf_lu_cnt
  , output logic [PERF_W-1:0] perf_mc_cnt
  , output logic [PERF_W-1:0] perf_mem_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } state_t;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(MC_LATENCY - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic mem_stall;
  logic load_use;
  logic mc_stall;
  logic ex_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_stall = bus.mem_req & ~bus.mem_ready;
    load_use  = bus.ex_mem_read & (bus.ex_rd != REG_ZERO) &
                ((bus.ex_rd == bus.id_rs1) | (bus.id_uses_rs2 & (bus.ex_rd == bus.id_rs2)));
    mc_stall  = ((state == IDLE) & bus.ex_mc_start) | (state == MC_BUSY);
    ex_hold   = mem_stall | mc_stall;

    // The functional unit counts down regardless of memory wait states.
    case (state)
      IDLE: begin
        if (bus.ex_mc_start) begin
          state_nxt = MC_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MC_BUSY: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = MC_DONE;
      end
      MC_DONE: begin
        if (!mem_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    bus.stall_mem  = ~rst & mem_stall;
    bus.bubble_wb  = ~rst & mem_stall;
    bus.stall_ex   = ~rst & ex_hold;
    bus.bubble_mem = ~rst & mc_stall & ~mem_stall;
    bus.stall_if   = ~rst & (ex_hold | load_use);
    bus.stall_id   = ~rst & (ex_hold | load_use);
    bus.bubble_ex  = ~rst & load_use & ~ex_hold;
    bus.fsm_state  = rst ? 2'd0 : state;
  end

`ifdef STALL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_cnt  <= '0;
      perf_mc_cnt  <= '0;
      perf_mem_cnt <= '0;
    end else begin
      if (load_use && !ex_hold && perf_lu_cnt != '1) perf_lu_cnt  <= perf_lu_cnt + PERF_ONE;
      if (mc_stall && perf_mc_cnt != '1)              perf_mc_cnt  <= perf_mc_cnt + PERF_ONE;
      if (mem_stall && perf_mem_cnt != '1)            perf_mem_cnt <= perf_mem_cnt + PERF_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_stall_controller.sv
// tb/tb_stall_controller.sv - directed self-checking bench for stall_controller
module tb_stall_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stall_controller_if #(.REG_ADDR_W(5)) bus ();

`ifdef STALL_PERF_EN
  logic [31:0] perf_lu_cnt, perf_mc_cnt, perf_mem_cnt;
`endif

  stall_controller #(
    .REG_ADDR_W(5),
    .MC_LATENCY(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef STALL_PERF_EN
    , .perf_lu_cnt(perf_lu_cnt)
    , .perf_mc_cnt(perf_mc_cnt)
    , .perf_mem_cnt(perf_mem_cnt)
`endif
  );

  // Packed view {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb}
  logic [6:0] outs;
  assign outs = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                 bus.bubble_ex, bus.bubble_mem, bus.bubble_wb};

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses2,
                        input logic [4:0] rd, input logic mr, input logic mc,
                        input logic req, input logic rdy);
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_uses_rs2 = uses2;
    bus.ex_rd       = rd;
    bus.ex_mem_read = mr;
    bus.ex_mc_start = mc;
    bus.mem_req     = req;
    bus.mem_ready   = rdy;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [6:0] exp_outs, input logic [1:0] exp_fsm);
    @(negedge clk);
    chk({tag, "_outs"}, 32'(outs), 32'(exp_outs));
    chk({tag, "_fsm"}, 32'(bus.fsm_state), 32'(exp_fsm));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset holds every output low even with all hazards asserted
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    cyc("rst_hold", 7'b0000000, 2'd0);
    rst = 1'b0;
    cyc("rst_release", 7'b1111001, 2'd0);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("rst_mc_b1", 7'b1110010, 2'd1);
    // Asynchronous reset mid-count abandons the op
    rst = 1'b1;
    #1;
    chk("rst_async_fsm", 32'(bus.fsm_state), 32'd0);
    chk("rst_async_outs", 32'(outs), 32'd0);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("idle", 7'b0000000, 2'd0);

    // Load-use
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs1", 7'b1100100, 2'd0);
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_clear", 7'b0000000, 2'd0);
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_x0", 7'b0000000, 2'd0);
    set_in(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs2_unused", 7'b0000000, 2'd0);
    set_in(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs2_used", 7'b1100100, 2'd0);

    // Multi-cycle op, ex_mc_start held 5 cycles
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mc_c1", 7'b1110010, 2'd0);
    cyc("mc_c2", 7'b1110010, 2'd1);
    cyc("mc_c3", 7'b1110010, 2'd1);
    cyc("mc_c4", 7'b1110010, 2'd1);
    cyc("mc_done", 7'b0000000, 2'd2);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mc_idle", 7'b0000000, 2'd0);

    // Memory wait with a coincident load-use: hold only, bubble deferred
    set_in(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("mem_w1_lu", 7'b1111001, 2'd0);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mem_w2", 7'b1111001, 2'd0);
    cyc("mem_w3", 7'b1111001, 2'd0);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("mem_ready", 7'b0000000, 2'd0);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef STALL_PERF_EN
    chk("perf_lu", perf_lu_cnt, 32'd2);
    chk("perf_mc", perf_mc_cnt, 32'd4);
    chk("perf_mem", perf_mem_cnt, 32'd3);
`endif

    // Overlap: mem_stall across the cnt==1 edge and two further cycles
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("ov_c1", 7'b1110010, 2'd0);
    cyc("ov_c2", 7'b1110010, 2'd1);
    cyc("ov_c3", 7'b1110010, 2'd1);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("ov_c4_mem", 7'b1111001, 2'd1);
    cyc("ov_done_w1", 7'b1111001, 2'd2);
    cyc("ov_done_w2", 7'b1111001, 2'd2);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("ov_done_rdy", 7'b0000000, 2'd2);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ov_idle", 7'b0000000, 2'd0);

    // Back-to-back: next op triggers normally from IDLE
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("b2b_c1", 7'b1110010, 2'd0);
    cyc("b2b_c2", 7'b1110010, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_controller.md
Name: stall_controller

Overview:
- Produces the per-stage stall (hold) and bubble (flush-to-NOP) controls for the 5-stage RISC-V pipeline.
- Its stall outputs drive the hold inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Stall sources:
  - load-use hazards
  - multi-cycle EX operations (iterative mul/div)
  - data-memory wait states
- Outputs are combinational (Mealy) from internal FSM state plus current inputs, so a stall takes effect in the same cycle the hazard appears.

Parameters:
REG_ADDR_W, 5, register-address width
MC_LATENCY, 4, total stall cycles for one multi-cycle EX op; legal 2..2**CNT_W
CNT_W, 3, multi-cycle counter width
PERF_W, 32, perf-counter width (only with STALL_PERF_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  rd of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_mc_start  in  1  EX holds a multi-cycle op; held high while that op sits in EX
mem_req  in  1  MEM stage is issuing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
stall_if  out  1  hold PC / IF-ID register
stall_id  out  1  hold ID/EX register inputs (ID stage)
stall_ex  out  1  hold EX stage / EX-MEM producer
stall_mem  out  1  hold MEM stage
bubble_ex  out  1  load NOP into ID/EX
bubble_mem  out  1  load NOP into EX/MEM
bubble_wb  out  1  load NOP into MEM/WB
fsm_state  out  2  debug: 0 IDLE, 1 MC_BUSY, 2 MC_DONE

Behaviour:
- Reset:
  - state=IDLE, cnt=0.
  - While rst=1, every stall/bubble output is forced to 0 and fsm_state=0.
  - Reset mid-operation abandons any multi-cycle count.
- Combinational terms:
  - mem_stall = mem_req & ~mem_ready
  - load_use = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & (ex_rd==id_rs2)))
  - mc_stall = (state==IDLE & ex_mc_start) | (state==MC_BUSY)
- Output equations:
  - stall_mem = bubble_wb = mem_stall
  - stall_ex = mem_stall | mc_stall
  - bubble_mem = mc_stall & ~mem_stall
  - stall_if = stall_id = stall_ex | load_use
  - bubble_ex = load_use & ~stall_ex (no bubble while EX is held)
- FSM, registered on clk:
  - IDLE:
    - ex_mc_start=1 -> MC_BUSY, cnt <= MC_LATENCY-1.
    - Entry is taken even if mem_stall=1; the functional unit runs independently.
  - MC_BUSY:
    - cnt decrements every cycle, including during mem_stall.
    - When cnt==1 -> MC_DONE.
    - Stall length = 1 entry cycle + (MC_LATENCY-1) busy cycles = MC_LATENCY cycles exactly.
  - MC_DONE:
    - mc_stall=0; ex_mc_start is ignored (the same op is still in EX).
    - Stays in MC_DONE while mem_stall=1, because EX cannot advance.
    - Otherwise -> IDLE next cycle.
- Back-to-back multi-cycle ops: the second op arrives in EX the cycle after MC_DONE exits and triggers normally in IDLE.
- Load-use:
  - Stateless; holds IF/ID for one cycle and inserts one EX bubble.
  - x0 destination never stalls.
  - If mem_stall coincides, only the hold applies; the bubble is deferred until EX advances.
- Priority is implicit via OR: mem_stall holds all stages; mc_stall holds IF..EX; load_use holds IF..ID.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - Adds outputs perf_lu_cnt, perf_mc_cnt, perf_mem_cnt, each PERF_W bits.
  - Each counter increments by 1 on every cycle its term is 1: load_use&~stall_ex, mc_stall, mem_stall.
  - Counters saturate at all-ones and are cleared by rst.
- Undefined: ports and counters are absent; no other behaviour change.

Test Plan:
- Reset: rst=1 with ex_mc_start=1, mem_req=1, mem_ready=0 -> all outputs 0. Release rst -> stall_ex=1 same cycle, fsm_state 0->1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> stall_if=stall_id=bubble_ex=1 for 1 cycle, stall_ex=0. Repeat with ex_rd=0 -> no stall. Repeat with rs2 match but id_uses_rs2=0 -> no stall.
- Multi-cycle, MC_LATENCY=4, ex_mc_start held 5 cycles:
  - stall_ex=bubble_mem=1 for exactly 4 cycles.
  - fsm_state sequence 0,1,1,1,2, then back to 0 with no re-trigger.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> stall_mem=stall_ex=stall_if=bubble_wb=1 for 3 cycles, all 0 on the ready cycle.
- Overlap: start multi-cycle op, then mem_stall across the cnt==1 edge and 2 further cycles:
  - cnt still expires on time.
  - FSM holds MC_DONE until mem_ready.
  - bubble_mem=0 whenever mem_stall=1.
- STALL_PERF_EN: run the scenarios above -> perf_lu_cnt=1, perf_mc_cnt=4, perf_mem_cnt=3. Force saturation with PERF_W=2 -> counters stick at 3.
